// File: rtl/seg7_pkg.sv
// seg7_pkg: shared 7-segment definitions for the hex encoder and the scan decoder.
// Contents: segment patterns (active-high, bit6=a .. bit0=g), segment bit indices,
// the decode result struct, the output-side state type and seg7_decode().
package seg7_pkg;

    // Segment bit positions within a pattern
    localparam int unsigned A = 6;
    localparam int unsigned B = 5;
    localparam int unsigned C = 4;
    localparam int unsigned D = 3;
    localparam int unsigned E = 2;
    localparam int unsigned F = 1;
    localparam int unsigned G = 0;

    // Active-high segment patterns for each hex digit
    localparam logic [6:0] SEG_0     = 7'h7E;
    localparam logic [6:0] SEG_1     = 7'h30;
    localparam logic [6:0] SEG_2     = 7'h6D;
    localparam logic [6:0] SEG_3     = 7'h79;
    localparam logic [6:0] SEG_4     = 7'h33;
    localparam logic [6:0] SEG_5     = 7'h5B;
    localparam logic [6:0] SEG_6     = 7'h5F;
    localparam logic [6:0] SEG_7     = 7'h70;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h7B;
    localparam logic [6:0] SEG_A     = 7'h77;
    localparam logic [6:0] SEG_B     = 7'h1F;
    localparam logic [6:0] SEG_C     = 7'h4E;
    localparam logic [6:0] SEG_D     = 7'h3D;
    localparam logic [6:0] SEG_E     = 7'h4F;
    localparam logic [6:0] SEG_F     = 7'h47;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    typedef struct packed {
        logic       err;
        logic       blank;
        logic [3:0] nibble;
    } seg7_dec_t;

    // Output register state: IDLE holds no frame, FULL holds an unaccepted frame
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_FULL = 1'b1
    } seg7_out_state_t;

    // Pattern -> nibble; blank and unknown patterns report nibble 0
    function automatic seg7_dec_t seg7_decode(input logic [6:0] pattern);
        seg7_dec_t res;
        res = '0;
        case (pattern)
            SEG_0:     res.nibble = 4'h0;
            SEG_1:     res.nibble = 4'h1;
            SEG_2:     res.nibble = 4'h2;
            SEG_3:     res.nibble = 4'h3;
            SEG_4:     res.nibble = 4'h4;
            SEG_5:     res.nibble = 4'h5;
            SEG_6:     res.nibble = 4'h6;
            SEG_7:     res.nibble = 4'h7;
            SEG_8:     res.nibble = 4'h8;
            SEG_9:     res.nibble = 4'h9;
            SEG_A:     res.nibble = 4'hA;
            SEG_B:     res.nibble = 4'hB;
            SEG_C:     res.nibble = 4'hC;
            SEG_D:     res.nibble = 4'hD;
            SEG_E:     res.nibble = 4'hE;
            SEG_F:     res.nibble = 4'hF;
            SEG_BLANK: res.blank  = 1'b1;
            default:   res.err    = 1'b1;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/seg7_pattern_decode.sv
// seg7_pattern_decode: combinational active-high 7-segment pattern to nibble.
// Ports:
//   i_pattern   in   7   segment pattern, bit6=a .. bit0=g, active-high
//   o_nibble_c  out  4   decoded hex value (0 for blank/unknown)
//   o_blank_c   out  1   all segments off
//   o_err_c     out  1   pattern not a hex digit
module seg7_pattern_decode
    import seg7_pkg::*;
(
    input  logic [6:0] i_pattern,
    output logic [3:0] o_nibble_c,
    output logic       o_blank_c,
    output logic       o_err_c
);

    seg7_dec_t w_dec;

    assign w_dec      = seg7_decode(i_pattern);
    assign o_nibble_c = w_dec.nibble;
    assign o_blank_c  = w_dec.blank;
    assign o_err_c    = w_dec.err;

endmodule

// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder: samples a multiplexed active-low 7-seg bus, debounces each
// digit, and emits complete decoded frames over valid/ready.
// Ports:
//   clk, rst_n   clock, async active-low reset
//   sample_en    qualifies dig_sel/seg this cycle
//   dig_sel      NDIG one-hot digit strobe
//   seg          7 active-low segments, bit6=a .. bit0=g
//   out_valid    frame held for the consumer
//   out_ready    consumer accepts frame
//   out_data     4*NDIG nibbles, nibble i in [4i+3:4i]
//   out_blank    NDIG per-digit blank flags
//   out_err      NDIG per-digit undecodable flags
//   sel_err      one-cycle pulse after a sample with non-one-hot dig_sel
module seg7_scan_decoder
    import seg7_pkg::*;
#(
    parameter int unsigned NDIG       = 4,
    parameter int unsigned STABLE_CNT = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sample_en,
    input  logic [NDIG-1:0]   dig_sel,
    input  logic [6:0]        seg,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [4*NDIG-1:0] out_data,
    output logic [NDIG-1:0]   out_blank,
    output logic [NDIG-1:0]   out_err,
    output logic              sel_err
);

    localparam int unsigned CW      = $clog2(STABLE_CNT + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CNT);

    logic [NDIG-1:0][6:0]    r_code;
    logic [NDIG-1:0][CW-1:0] r_cnt;
    logic [NDIG-1:0][6:0]    r_last;
    logic                    r_have_last;
    seg7_out_state_t         r_state;
    logic                    r_out_valid;
    logic [4*NDIG-1:0]       r_out_data;
    logic [NDIG-1:0]         r_out_blank;
    logic [NDIG-1:0]         r_out_err;
    logic                    r_sel_err;

    logic [6:0]        w_pattern;
    logic              w_sel_ok;
    logic [4*NDIG-1:0] w_nib;
    logic [NDIG-1:0]   w_blank;
    logic [NDIG-1:0]   w_err;
    logic [NDIG-1:0]   w_stable;
    logic              w_frame_ready;
    logic              w_emit;

    assign w_pattern = ~seg;
    assign w_sel_ok  = $onehot(dig_sel);

    // Per-digit decode of the currently held code and its stability flag
    for (genvar g = 0; g < NDIG; g++) begin : g_dig
        seg7_pattern_decode u_dec (
            .i_pattern  (r_code[g]),
            .o_nibble_c (w_nib[4*g +: 4]),
            .o_blank_c  (w_blank[g]),
            .o_err_c    (w_err[g])
        );
        assign w_stable[g] = (r_cnt[g] == CNT_MAX);
    end

    // Codes are compared as raw patterns so distinct bad patterns still count as a change
    assign w_frame_ready = (&w_stable) && (!r_have_last || (r_code != r_last));
    assign w_emit        = w_frame_ready && (!r_out_valid || out_ready);

    // Per-digit glitch filter: restart on a new pattern, saturate on repeats
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_code    <= '0;
            r_cnt     <= '0;
            r_sel_err <= 1'b0;
        end else begin
            r_sel_err <= sample_en && !w_sel_ok;
            if (sample_en && w_sel_ok) begin
                for (int i = 0; i < NDIG; i++) begin
                    if (dig_sel[i]) begin
                        if (w_pattern == r_code[i]) begin
                            if (r_cnt[i] != CNT_MAX) begin
                                r_cnt[i] <= r_cnt[i] + CW'(1);
                            end
                        end else begin
                            r_code[i] <= w_pattern;
                            r_cnt[i]  <= CW'(1);
                        end
                    end
                end
            end
        end
    end

    // Output one-entry buffer: load on emit, drain on accept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_blank <= '0;
            r_out_err   <= '0;
            r_last      <= '0;
            r_have_last <= 1'b0;
        end else begin
            if (w_emit) begin
                r_out_data  <= w_nib;
                r_out_blank <= w_blank;
                r_out_err   <= w_err;
                r_last      <= r_code;
                r_have_last <= 1'b1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_emit) begin
                        r_out_valid <= 1'b1;
                        r_state     <= ST_FULL;
                    end
                end
                ST_FULL: begin
                    if (out_ready && !w_emit) begin
                        r_out_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_blank = r_out_blank;
    assign out_err   = r_out_err;
    assign sel_err   = r_sel_err;

endmodule
